interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Interrupt source for the pipelined nand_cpu: captures rising edges on external request lines, applies a software mask, picks the highest-priority pending source and drives the request/vector handshake into the fetch unit's interrupt handler port. The fetch unit acknowledges the request when it redirects the PC and signals completion on return-from-interrupt. One request is outstanding at a time, and there is no nesting.

## Interface
Parameters:
- N_SRC, 4: number of interrupt sources, legal range 2..8; source 0 has the highest priority.
- VECTOR_BASE, 8'hF0: handler address for source 0.
- VECTOR_STRIDE, 8'h04: address spacing between consecutive source vectors.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- irq  in  N_SRC  request lines, synchronous to clk; rising edge requests service.
- halted  in  1  CPU halted; suppresses new requests.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  N_SRC  new mask value; bit = 1 masks that source.
- int_ack  in  1  fetch unit took the vector this cycle.
- int_done  in  1  handler returned.
- int_req  out  1  interrupt request to the fetch unit.
- int_vector  out  8  handler PC; stable while int_req = 1.
- int_id  out  clog2(N_SRC)  source being requested or serviced.
- in_service  out  1  handler currently running.
- pending  out  N_SRC  captured, unserviced edges.
- mask  out  N_SRC  current mask register.

## Operation
- Edge capture uses an irq_prev register, with edge = irq & ~irq_prev. Any edge sets the matching pending bit at the next clock edge, regardless of mask, state or halted.
- Eligible sources = pending & ~mask. The selected source is the lowest-index eligible bit.
- Vector = VECTOR_BASE + sel * VECTOR_STRIDE, computed mod 256 (8-bit wrap, no error).
- mask_we loads mask from mask_wdata at the clock edge. The new mask affects selection from the following cycle. Writes are accepted in every state.
- FSM states are IDLE, REQ and SERVICE:
  - IDLE → REQ when eligible ≠ 0 and halted = 0. In that same edge, int_id and int_vector latch the selected source.
  - REQ → SERVICE on int_ack. In that same edge, pending[int_id] clears.
  - REQ holds int_id and int_vector fixed. There is no re-selection, even if a higher-priority source arrives, the source becomes masked, or halted rises.
  - SERVICE → IDLE on int_done.
- Outputs by state:
  - int_req = (state == REQ).
  - in_service = (state == SERVICE).
  - int_id and int_vector keep their last latched value in IDLE and SERVICE.
- int_ack outside REQ is ignored. int_done outside SERVICE is ignored.
- If an edge arrives on source k in the same cycle that pending[k] is cleared by ack, the set wins and pending[k] stays 1.
- Edges on an already-pending source do not accumulate; there is a single bit per source.

## Timing
- Reset values:
  - state = IDLE, int_req = 0, in_service = 0.
  - pending = 0, irq_prev = 0.
  - mask = all ones (all sources masked).
  - int_id = 0, int_vector = VECTOR_BASE.
- If irq is held high during reset, it produces an edge on the first cycle after reset.
- Latency, with irq rising before edge k:
  - pending is set after edge k.
  - int_req = 1 after edge k+1 (2 cycles), provided the source is unmasked, state is IDLE and halted = 0.
- int_ack sampled at edge m drops int_req after edge m, so the minimum REQ duration is one cycle.
- int_done sampled at edge n returns to IDLE after edge n. The earliest next int_req is after edge n+1.
- Asserting rst in any state returns every register to its reset value immediately. In-flight requests and pending edges are lost.
- All outputs are registered or decoded only from state, with no combinational path from inputs to outputs.

## Test plan
- Reset/mask default: rst, then pulse irq[2] with mask = 4'hF → pending = 4'b0100, int_req stays 0. Then write mask = 4'h0 → int_req = 1 two cycles later, int_id = 2, int_vector = 8'hF8.
- Priority: mask = 0, irq[3] and irq[1] rise together → int_id = 1, vector 8'hF4. After ack and done → int_id = 3, vector 8'hFC, and pending ends at 0.
- Handshake: hold int_ack low for 5 cycles → int_req and vector stay stable. Raise irq[0] mid-REQ → int_id unchanged, pending[0] = 1. int_done pulsed during REQ → ignored.
- Ack/edge collision: irq[1] re-rises in the same cycle int_ack clears pending[1] → pending[1] = 1 after the edge, and a second request follows after done.
- Halt and wrap: halted = 1 with pending eligible → no int_req until halted drops. With VECTOR_BASE = 8'hFC, STRIDE = 4, source 1 → vector 8'h00.
- Async reset mid-SERVICE: assert rst between clock edges → in_service = 0, pending = 0 and mask = 4'hF, all without waiting for a clock edge.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-captured, masked, fixed-priority interrupt source with req/ack/done handshake
module interrupt_controller #(
  parameter int N_SRC = 4,
  parameter logic [7:0] VECTOR_BASE = 8'hF0,
  parameter logic [7:0] VECTOR_STRIDE = 8'h04
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           irq,
  input  logic                       halted,
  input  logic                       mask_we,
  input  logic [N_SRC-1:0]           mask_wdata,
  input  logic                       int_ack,
  input  logic                       int_done,
  output logic                       int_req,
  output logic [7:0]                 int_vector,
  output logic [$clog2(N_SRC)-1:0]   int_id,
  output logic                       in_service,
  output logic [N_SRC-1:0]           pending,
  output logic [N_SRC-1:0]           mask
);
  localparam int IW = $clog2(N_SRC);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_nxt;
  logic [N_SRC-1:0] irq_prev, eligible, clr;
  logic [IW-1:0] sel;
  logic [7:0] sel_vector;
  assign eligible = pending & ~mask;
  // lowest-index eligible source wins and its vector is formed mod 256
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (eligible[i]) sel = IW'(i);
    sel_vector = VECTOR_BASE + 8'(sel) * VECTOR_STRIDE;
    clr = (state == REQ && int_ack) ? (N_SRC'(1) << int_id) : '0;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next-state: ack and done only act in their own state
  always_comb
    state_nxt = (state == IDLE && eligible != '0 && !halted) ? REQ :
                (state == REQ && int_ack) ? SERVICE :
                (state == SERVICE && int_done) ? IDLE : state;
  // outputs decoded from state only
  always_comb begin
    int_req = (state == REQ);
    in_service = (state == SERVICE);
  end
  // edge capture, mask register and request latch; a new edge beats an ack clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irq_prev <= '0;
      pending <= '0;
      mask <= '1;
      int_id <= '0;
      int_vector <= VECTOR_BASE;
    end else begin
      irq_prev <= irq;
      pending <= (pending & ~clr) | (irq & ~irq_prev);
      if (mask_we) mask <= mask_wdata;
      if (state == IDLE && state_nxt == REQ) begin
        int_id <= sel;
        int_vector <= sel_vector;
      end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scoreboard bench for interrupt_controller
module tb_interrupt_controller;
  logic clk = 0, rst = 1, halted = 0, mask_we = 0, int_ack = 0, int_done = 0;
  logic [3:0] irq = 0, mask_wdata = 0;
  logic int_req, in_service, int_req2, in_service2;
  logic [7:0] int_vector, int_vector2;
  logic [1:0] int_id, int_id2;
  logic [3:0] pending, mask, pending2, mask2;
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] id; logic [7:0] v; logic [7:0] v2;} exp_t;
  exp_t exp_q[$];
  logic [7:0] v0;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .irq(irq), .halted(halted), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_ack(int_ack), .int_done(int_done),
    .int_req(int_req), .int_vector(int_vector), .int_id(int_id),
    .in_service(in_service), .pending(pending), .mask(mask)
  );

  interrupt_controller #(.N_SRC(4), .VECTOR_BASE(8'hFC), .VECTOR_STRIDE(8'h04)) dut2 (
    .clk(clk), .rst(rst), .irq(irq), .halted(halted), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_ack(int_ack), .int_done(int_done),
    .int_req(int_req2), .int_vector(int_vector2), .int_id(int_id2),
    .in_service(in_service2), .pending(pending2), .mask(mask2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] vec(input logic [7:0] b, input int id);
    return 8'(b + id * 4);
  endfunction

  task automatic push_exp(input int id);
    exp_q.push_back('{id[1:0], vec(8'hF0, id), vec(8'hFC, id)});
  endtask

  task automatic wait_req(input string tag);
    exp_t e;
    int n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " req"}, int_req, 1);
    if (exp_q.size() == 0) check({tag, " queue"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      check({tag, " id"}, int_id, e.id);
      check({tag, " vector"}, int_vector, e.v);
      check({tag, " wrap vector"}, int_vector2, e.v2);
    end
  endtask

  task automatic serve(input string tag);
    int_ack = 1;
    tick();
    int_ack = 0;
    check({tag, " in_service"}, in_service, 1);
    check({tag, " req dropped"}, int_req, 0);
    int_done = 1;
    tick();
    int_done = 0;
    check({tag, " back idle"}, in_service, 0);
  endtask

  initial begin
    tick();
    check("rst int_req", int_req, 0);
    check("rst in_service", in_service, 0);
    check("rst pending", pending, 0);
    check("rst mask", mask, 4'hF);
    check("rst int_id", int_id, 0);
    check("rst vector", int_vector, 8'hF0);
    check("rst vector2", int_vector2, 8'hFC);
    rst = 0;
    tick();
    irq = 4'b0100;
    tick();
    irq = 0;
    check("masked pending", pending, 4'b0100);
    tick();
    tick();
    check("masked no req", int_req, 0);
    mask_we = 1;
    mask_wdata = 4'h0;
    push_exp(2);
    tick();
    mask_we = 0;
    check("mask loaded", mask, 4'h0);
    check("req latency", int_req, 0);
    wait_req("unmask");
    v0 = int_vector;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) irq = 4'b0001;
      if (i == 4) irq = 0;
      tick();
      check("hold req", int_req, 1);
      check("hold vector", int_vector, v0);
      check("hold id", int_id, 2);
    end
    check("mid-req pending", pending, 4'b0101);
    int_done = 1;
    tick();
    int_done = 0;
    check("done in req ignored", int_req, 1);
    check("done in req no svc", in_service, 0);
    serve("src2");
    check("src2 cleared", pending, 4'b0001);
    push_exp(0);
    wait_req("src0");
    serve("src0");
    check("src0 cleared", pending, 0);
    irq = 4'b1010;
    tick();
    irq = 0;
    push_exp(1);
    push_exp(3);
    wait_req("prio first");
    serve("prio first");
    wait_req("prio second");
    serve("prio second");
    check("prio pending empty", pending, 0);
    irq = 4'b0010;
    tick();
    irq = 0;
    push_exp(1);
    wait_req("collide first");
    irq = 4'b0010;
    int_ack = 1;
    tick();
    int_ack = 0;
    irq = 0;
    check("collide pending kept", pending, 4'b0010);
    check("collide in_service", in_service, 1);
    int_done = 1;
    tick();
    int_done = 0;
    push_exp(1);
    wait_req("collide second");
    serve("collide second");
    check("collide pending empty", pending, 0);
    halted = 1;
    irq = 4'b0100;
    tick();
    irq = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halted no req", int_req, 0);
    end
    check("halted pending", pending, 4'b0100);
    halted = 0;
    push_exp(2);
    wait_req("unhalt");
    serve("unhalt");
    irq = 4'b1000;
    tick();
    irq = 0;
    push_exp(3);
    wait_req("pre-reset");
    int_ack = 1;
    tick();
    int_ack = 0;
    irq = 4'b0001;
    tick();
    irq = 0;
    check("pre-reset svc", in_service, 1);
    check("pre-reset pending", pending, 4'b0001);
    mask_we = 1;
    mask_wdata = 4'h2;
    tick();
    mask_we = 0;
    check("mask write in svc", mask, 4'h2);
    #2 rst = 1;
    irq = 4'b1000;
    #1;
    check("async in_service", in_service, 0);
    check("async pending", pending, 0);
    check("async mask", mask, 4'hF);
    check("async int_req", int_req, 0);
    check("async vector", int_vector, 8'hF0);
    tick();
    rst = 0;
    tick();
    check("irq held in reset edge", pending, 4'b1000);
    irq = 0;
    tick();
    check("post-reset idle", int_req, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
